imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 14: IMEM word-address width, matching the IMEM write port.
REQ-002 Parameter MAGIC, default 8'hA5: frame start byte.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 rx_data  input  8: incoming byte from the UART receiver.
REQ-006 rx_valid  input  1: rx_data valid; a byte transfers when rx_valid and rx_ready are both high at a rising edge.
REQ-007 rx_ready  output  1: loader can accept a byte.
REQ-008 abort  input  1: synchronous request to drop the current frame.
REQ-009 imem_wea  output  4: IMEM byte write enables.
REQ-010 imem_addra  output  ADDR_W: IMEM word address.
REQ-011 imem_dina  output  32: IMEM write data.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 done  output  1: one-cycle pulse when a frame completes successfully.
REQ-014 error  output  1: one-cycle pulse on a bad magic byte or checksum mismatch.

Function
REQ-015 The frame format SHALL be: MAGIC, start address (2 bytes, little-endian, low ADDR_W bits used), word count N (2 bytes, little-endian), 4N data bytes (little-endian per word), then a checksum byte only when the checksum feature is enabled.
REQ-016 The states SHALL be IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, WRITE, CSUM, and each header state SHALL advance by one state per accepted byte.
REQ-017 rx_ready SHALL be high in IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA and CSUM, and low in WRITE.
REQ-018 In IDLE, a byte other than MAGIC SHALL be consumed and discarded, SHALL pulse error in the following cycle, and the loader SHALL remain in IDLE.
REQ-019 If N equals 0 after CNT1, the loader SHALL go to CSUM when the checksum feature is enabled, otherwise to IDLE with done pulsed.
REQ-020 In DATA, bytes SHALL be shifted into a 32-bit assembly register with the first byte in bits [7:0]; the 4th byte SHALL move the loader to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with imem_wea equal to 4'b1111 and imem_dina equal to the assembled word; the write SHALL occur one cycle after the 4th byte's handshake.
REQ-022 imem_addra SHALL be the start address for the first word and SHALL increment by 1 after each write, wrapping modulo 2^ADDR_W.
REQ-023 After WRITE, the loader SHALL go to DATA if words remain; otherwise to CSUM (feature on), or to IDLE with done pulsed in the same cycle (feature off).
REQ-024 imem_wea SHALL be 4'b0000 in every state other than WRITE.
REQ-025 abort SHALL have priority over byte acceptance and writes: the next state SHALL be IDLE, the partial word SHALL be discarded, no write SHALL occur, and neither done nor error SHALL pulse.
REQ-026 A byte presented in the same cycle as abort SHALL not be consumed.
REQ-027 The remaining-word counter SHALL be 16 bits, allowing N up to 65535.

Reset
REQ-028 While rst is low, the loader SHALL be in IDLE, and imem_wea, imem_addra, imem_dina, busy, done, error, the counters and the checksum accumulator SHALL all be 0.
REQ-029 rx_ready SHALL be 0 during reset and SHALL be 1 from the first cycle after reset deasserts.
REQ-030 Reset asserted mid-frame, including during WRITE, SHALL abandon the frame with no further IMEM write.

Configuration
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, an 8-bit sum of all data bytes (mod 256) SHALL be accumulated.
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, the byte received in CSUM SHALL be compared with the sum: on a match, done SHALL pulse; on a mismatch, error SHALL pulse; in both cases the loader SHALL go to IDLE.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, words already written SHALL not be rolled back on a mismatch.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent and no checksum byte SHALL be expected.

Structure
REQ-035 The state enum, the MAGIC default and the frame header byte count SHALL live in the shared package imem_loader_pkg.
REQ-036 Word assembly (shift register plus byte counter) SHALL be a sub-module named byte_packer; all other logic SHALL be inline.

Verification
REQ-037 Frame A5 00 10 02 00 + 8 data bytes 11 22 33 44 55 66 77 88 SHALL give writes 0x44332211 at 0x1000 and 0x88776655 at 0x1001, each one cycle after the 4th byte, followed by done.
REQ-038 Start address 0x3FFF with N=2 SHALL give writes at 0x3FFF then 0x0000.
REQ-039 Leading byte 0x5A SHALL pulse error and leave the loader in IDLE; a valid frame immediately after it SHALL load correctly.
REQ-040 abort asserted after 2 of the 4 data bytes of a word SHALL cause no write, busy to fall in the next cycle, and a following frame SHALL be accepted.
REQ-041 With IMEM_LOADER_CHECKSUM_EN, checksum 0x24 for data 11 22 33 44 (sum 0xAA) SHALL pulse error, and checksum 0xAA SHALL pulse done.
REQ-042 rst dropped during WRITE SHALL immediately clear imem_wea to 0 and return the loader to IDLE.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART-to-IMEM frame loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam logic [7:0] MAGIC_DEF = 8'hA5;
    localparam int HDR_BYTES = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_WRITE
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, IMEM write port out.
// The loader sits on the slave side; the host/bench on the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_wea,
        input  imem_addra, imem_dina
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_wea,
        output imem_addra, imem_dina
    );
endinterface

// File: rtl/byte_packer.sv
// Assembles four bytes into a little-endian 32-bit word.
// last flags that the next shifted byte completes the word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            word <= {din, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end

    assign last = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Frame loader: MAGIC, addr, count, data words -> IMEM writes.
// IMEM_LOADER_CHECKSUM_EN enables the trailing 8-bit sum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 14,
    parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
    imem_loader_if.slave bus,
    output logic busy,
    output logic done,
    output logic error
);

    state_t            state;
    logic              ready_q;
    logic [3:0]        wea_q;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       cnt;
    logic [7:0]        hdr_lo;
    logic [15:0]       hdr16;
    logic [31:0]       word;
    logic              acc;
    logic              shift_en;
    logic              pk_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign acc      = bus.rx_valid & ready_q & ~abort;
    assign shift_en = acc & (state == S_DATA);
    assign hdr16    = {bus.rx_data, hdr_lo};

    byte_packer u_pack (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .shift_en (shift_en),
        .din      (bus.rx_data),
        .word     (word),
        .last     (pk_last)
    );

    // abort also masks a write already on the port this cycle
    assign bus.rx_ready   = ready_q;
    assign bus.imem_wea   = abort ? 4'h0 : wea_q;
    assign bus.imem_addra = addr;
    assign bus.imem_dina  = word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            wea_q   <= '0;
            addr    <= '0;
            cnt     <= '0;
            hdr_lo  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            ready_q <= 1'b1;
            wea_q   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (acc && bus.rx_data == MAGIC) begin
                            state <= S_ADDR0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end else begin
                            busy  <= 1'b0;
                            error <= acc;
                        end
                    end
                    S_ADDR0: if (acc) begin
                        hdr_lo <= bus.rx_data;
                        state  <= S_ADDR1;
                    end
                    S_ADDR1: if (acc) begin
                        addr  <= hdr16[ADDR_W-1:0];
                        state <= S_CNT0;
                    end
                    S_CNT0: if (acc) begin
                        hdr_lo <= bus.rx_data;
                        state  <= S_CNT1;
                    end
                    S_CNT1: if (acc) begin
                        cnt <= hdr16;
                        if (hdr16 != 16'd0) begin
                            state <= S_DATA;
                        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                    S_DATA: if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum + bus.rx_data;
`endif
                        if (pk_last) begin
                            state   <= S_WRITE;
                            wea_q   <= 4'hF;
                            ready_q <= 1'b0;
                        end
                    end
                    S_WRITE: begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 16'd1;
                        if (cnt != 16'd1) begin
                            state <= S_DATA;
                        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: if (acc) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= (bus.rx_data == csum);
                        error <= (bus.rx_data != csum);
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and random frames against a byte-list reference model.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error;

    imem_loader_if #(.ADDR_W(AW)) bus();

    imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk   (clk),
        .rst   (rst),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr_seen = 0;
    int n_wr_exp = 0;
    bit rand_gaps = 0;
    logic [7:0] dq[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs_xor = 8'h00;
`endif

    always @(negedge clk)
        if (rst && bus.imem_wea !== 4'h0) n_wr_seen++;

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (rand_gaps) repeat ($urandom_range(0, 2)) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $error("FAIL rx_ready_timeout: observed 0 expected 1");
        end
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] start, input logic [15:0] n);
        send_byte(MAGIC_DEF);
        chk("busy_hdr", busy, 1);
        send_byte(start[7:0]);
        send_byte(start[15:8]);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic fill_rand(input int n);
        dq.delete();
        for (int i = 0; i < 4 * n; i++) dq.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends a full frame from dq and checks each write as it happens.
    task automatic send_frame(input logic [15:0] start, input int n);
        logic [7:0]  sum;
        logic [31:0] w;
        int          ea;
        sum = 8'h00;
        send_hdr(start, 16'(n));
        for (int i = 0; i < n; i++) begin
            w = {dq[4*i+3], dq[4*i+2], dq[4*i+1], dq[4*i]};
            ea = (int'(start) + i) % (1 << AW);
            for (int j = 0; j < 4; j++) begin
                send_byte(dq[4*i+j]);
                sum = sum + dq[4*i+j];
            end
            chk("wea", bus.imem_wea, 4'hF);
            chk("addra", bus.imem_addra, ea);
            chk("dina", bus.imem_dina, w);
            n_wr_exp++;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum ^ cs_xor);
        chk("done_cs", done, (cs_xor == 8'h00) ? 1 : 0);
        chk("error_cs", error, (cs_xor != 8'h00) ? 1 : 0);
`else
        if (n > 0) begin
            chk("busy_write", busy, 1);
            tick();
        end
        chk("done", done, 1);
        chk("error", error, 0);
`endif
        chk("wea_after", bus.imem_wea, 0);
        chk("busy_end", busy, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        logic [7:0] fix[8];
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        #2;
        chk("rst_ready", bus.rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wea", bus.imem_wea, 0);
        chk("rst_addra", bus.imem_addra, 0);
        chk("rst_dina", bus.imem_dina, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("ready_after_rst", bus.rx_ready, 1);

        fix = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        dq.delete();
        for (int i = 0; i < 8; i++) dq.push_back(fix[i]);
        send_frame(16'h1000, 2);

        fill_rand(2);
        send_frame(16'h3FFF, 2);

        send_byte(8'h5A);
        chk("bad_magic_err", error, 1);
        chk("bad_magic_busy", busy, 0);
        tick();
        chk("bad_magic_pulse", error, 0);
        fill_rand(1);
        send_frame(16'h0123, 1);

        send_hdr(16'h0020, 16'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        abort        = 1'b1;
        bus.rx_data  = 8'hBE;
        bus.rx_valid = 1'b1;
        tick();
        abort        = 1'b0;
        bus.rx_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wea", bus.imem_wea, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        fill_rand(1);
        send_frame(16'h0200, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        dq.delete();
        for (int i = 0; i < 4; i++) dq.push_back(fix[i]);
        cs_xor = 8'hAA ^ 8'h24;
        send_frame(16'h0300, 1);
        cs_xor = 8'h00;
        send_frame(16'h0301, 1);
`endif

        dq.delete();
        send_frame(16'h0055, 0);

        send_hdr(16'h0010, 16'd1);
        for (int j = 0; j < 4; j++) send_byte(8'(8'hC0 + j));
        chk("wr_before_rst", bus.imem_wea, 4'hF);
        rst = 1'b0;
        #1;
        chk("rst_mid_wea", bus.imem_wea, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", bus.rx_ready, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("ready_after_rst2", bus.rx_ready, 1);

        rand_gaps = 1;
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 4);
            fill_rand(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
            cs_xor = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
`endif
            send_frame(16'($urandom), n);
        end

        tick();
        chk("write_count", n_wr_seen, n_wr_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
